// File: rtl/cmd_pkg.sv
// Shared types and constants for the command parser: FSM state encoding,
// command byte field positions and the default write-acknowledge byte.
package cmd_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_DATA = 3'd1,
        WRITE    = 3'd2,
        READ     = 3'd3,
        SEND     = 3'd4
    } cmd_state_e;

    localparam int CMD_WR_BIT = 7;
    localparam int CMD_ADDR_W = 7;
    localparam int DATA_W     = 8;

    localparam logic [DATA_W-1:0] ACK_BYTE_DEFAULT = 8'hA5;

    // Command byte decode helpers.
    function automatic logic cmd_is_write(input logic [DATA_W-1:0] b);
        return b[CMD_WR_BIT];
    endfunction

    function automatic logic [CMD_ADDR_W-1:0] cmd_addr(input logic [DATA_W-1:0] b);
        return b[CMD_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/cmd_parser_timer.sv
// Clear/enable cycle counter for the write-data timeout. expire_o is high while
// the count sits at LIMIT-1; LIMIT = 0 removes the counter entirely.
module cmd_timer #(
    parameter int unsigned LIMIT = 1000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    generate
        if (LIMIT == 0) begin : g_off
            logic unused_tie;
            assign unused_tie = &{1'b0, clk_i, rst_n_i, clr_i, en_i};
            assign expire_o   = 1'b0;
        end else begin : g_on
            localparam int W = $clog2(LIMIT + 1);
            localparam logic [W-1:0] LAST = W'(LIMIT - 1);

            logic [W-1:0] count_q;
            logic [W-1:0] count_d;

            always_comb begin
                count_d = count_q;
                if (clr_i) begin
                    count_d = '0;
                end else if (en_i) begin
                    count_d = count_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expire_o = (count_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/cmd_parser.sv
// Serial command parser driving a register file: 1-byte reads, 2-byte writes,
// read data returned on a valid/ready TX port. CMD_ACK_EN adds a write ACK byte.
module cmd_parser
    import cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
`ifdef CMD_ACK_EN
    ,
    parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEFAULT
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_W-1:0]     rx_data_i,
    input  logic                  rx_valid_i,
    output logic [DATA_W-1:0]     tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic [CMD_ADDR_W-1:0] address_o,
    output logic                  wr_o,
    output logic                  data_received_o,
    output logic [DATA_W-1:0]     data_o,
    input  logic [DATA_W-1:0]     reg_data_i,
    output logic                  busy_o,
    output logic                  drop_o,
    output logic                  timeout_o
);

    // TX handshake: a byte transfers on a cycle where tx_valid_o && tx_ready_i;
    // once raised, tx_valid_o and tx_data_o stay constant until that cycle.

    cmd_state_e state_q, state_d;

    logic [CMD_ADDR_W-1:0] address_q, address_d;
    logic                  wr_q, wr_d;
    logic                  drx_q, drx_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [DATA_W-1:0]     tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  busy_q, busy_d;
    logic                  drop_q, drop_d;
    logic                  timeout_q, timeout_d;

    logic timer_clr;
    logic timer_en;
    logic timer_expire;
    logic tx_fire;

    assign tx_fire = tx_valid_q && tx_ready_i;

    // The timer only runs while waiting for a data byte, so it is zero on entry.
    assign timer_clr = (state_q != GET_DATA);
    assign timer_en  = (state_q == GET_DATA) && !rx_valid_i;

    cmd_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clr_i    (timer_clr),
        .en_i     (timer_en),
        .expire_o (timer_expire)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rx_valid_i) begin
                    state_d = cmd_is_write(rx_data_i) ? GET_DATA : READ;
                end
            end
            GET_DATA: begin
                if (rx_valid_i) begin
                    state_d = WRITE;
                end else if (timer_expire) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
`ifdef CMD_ACK_EN
                state_d = SEND;
`else
                state_d = IDLE;
`endif
            end
            READ: begin
                state_d = SEND;
            end
            SEND: begin
                if (tx_fire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        address_d  = address_q;
        wr_d       = wr_q;
        data_d     = data_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        drx_d      = 1'b0;
        drop_d     = 1'b0;
        timeout_d  = 1'b0;
        busy_d     = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                if (rx_valid_i) begin
                    address_d = cmd_addr(rx_data_i);
                    wr_d      = cmd_is_write(rx_data_i);
                end
            end
            GET_DATA: begin
                // Any byte here is write data, even one with the write bit set.
                if (rx_valid_i) begin
                    data_d = rx_data_i;
                    drx_d  = 1'b1;
                end else if (timer_expire) begin
                    wr_d      = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            WRITE: begin
                wr_d   = 1'b0;
                drop_d = rx_valid_i;
`ifdef CMD_ACK_EN
                tx_data_d  = ACK_BYTE;
                tx_valid_d = 1'b1;
`endif
            end
            READ: begin
                tx_data_d  = reg_data_i;
                tx_valid_d = 1'b1;
                drop_d     = rx_valid_i;
            end
            SEND: begin
                if (tx_fire) begin
                    tx_valid_d = 1'b0;
                end
                drop_d = rx_valid_i;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            address_q  <= '0;
            wr_q       <= 1'b0;
            drx_q      <= 1'b0;
            data_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            address_q  <= address_d;
            wr_q       <= wr_d;
            drx_q      <= drx_d;
            data_q     <= data_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
            timeout_q  <= timeout_d;
        end
    end

    assign address_o       = address_q;
    assign wr_o            = wr_q;
    assign data_received_o = drx_q;
    assign data_o          = data_q;
    assign tx_data_o       = tx_data_q;
    assign tx_valid_o      = tx_valid_q;
    assign busy_o          = busy_q;
    assign drop_o          = drop_q;
    assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_cmd_parser.sv
// Bench for cmd_parser: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_cmd_parser;

  localparam int TO = 8;
  localparam logic [7:0] ACK = 8'hA5;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready;
  logic [6:0] address_o;
  logic       wr_o;
  logic       data_received_o;
  logic [7:0] data_o;
  logic [7:0] reg_data;
  logic       busy_o;
  logic       drop_o;
  logic       timeout_o;

  int n_vec = 0;
  int n_err = 0;

  cmd_parser #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .rx_data_i       (rx_data),
    .rx_valid_i      (rx_valid),
    .tx_data_o       (tx_data_o),
    .tx_valid_o      (tx_valid_o),
    .tx_ready_i      (tx_ready),
    .address_o       (address_o),
    .wr_o            (wr_o),
    .data_received_o (data_received_o),
    .data_o          (data_o),
    .reg_data_i      (reg_data),
    .busy_o          (busy_o),
    .drop_o          (drop_o),
    .timeout_o       (timeout_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // register file environment, written by the DUT's strobe
  logic [7:0] env_regs [128];
  assign reg_data = env_regs[address_o];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) env_regs[i] <= 8'(i) ^ 8'h5A;
    end else if (data_received_o) begin
      env_regs[address_o] <= data_o;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // behavioural model: expected output values after each clock edge
  logic [7:0] m_regs [128];
  logic [6:0] e_addr;
  logic [7:0] e_data, e_tx_data;
  bit e_wr, e_drx, e_tx_valid, e_busy, e_drop, e_timeout;
  bit waiting, reading, was_strobe;
  int waited;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) m_regs[i] = 8'(i) ^ 8'h5A;
      e_addr = 0; e_data = 0; e_tx_data = 0;
      e_wr = 0; e_drx = 0; e_tx_valid = 0; e_busy = 0; e_drop = 0; e_timeout = 0;
      waiting = 0; reading = 0; waited = 0;
    end else begin
      was_strobe = e_drx;
      e_drx = 0;
      e_drop = 0;
      e_timeout = 0;
      if (!e_busy) begin
        if (rx_valid) begin
          e_addr = rx_data[6:0];
          e_wr = rx_data[7];
          e_busy = 1;
          if (rx_data[7]) begin
            waiting = 1;
            waited = 0;
          end else begin
            reading = 1;
          end
        end
      end else if (waiting) begin
        if (rx_valid) begin
          e_data = rx_data;
          e_drx = 1;
          waiting = 0;
        end else if (TO != 0 && waited == TO - 1) begin
          waiting = 0;
          e_wr = 0;
          e_busy = 0;
          e_timeout = 1;
        end else begin
          waited++;
        end
      end else begin
        if (rx_valid) e_drop = 1;
        if (was_strobe) begin
          m_regs[e_addr] = e_data;
          e_wr = 0;
`ifdef CMD_ACK_EN
          e_tx_data = ACK;
          e_tx_valid = 1;
`else
          e_busy = 0;
`endif
        end else if (reading) begin
          reading = 0;
          e_tx_data = m_regs[e_addr];
          e_tx_valid = 1;
        end else if (e_tx_valid && tx_ready) begin
          e_tx_valid = 0;
          e_busy = 0;
        end
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (rst_n) begin
      chk("address_o", 32'(address_o), 32'(e_addr));
      chk("wr_o", 32'(wr_o), 32'(e_wr));
      chk("data_received_o", 32'(data_received_o), 32'(e_drx));
      chk("data_o", 32'(data_o), 32'(e_data));
      chk("tx_valid_o", 32'(tx_valid_o), 32'(e_tx_valid));
      chk("tx_data_o", 32'(tx_data_o), 32'(e_tx_data));
      chk("busy_o", 32'(busy_o), 32'(e_busy));
      chk("drop_o", 32'(drop_o), 32'(e_drop));
      chk("timeout_o", 32'(timeout_o), 32'(e_timeout));
    end
  end

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    tx_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (busy_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("drain_idle", 32'(busy_o), 32'd0);
    tx_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(address_o), 32'd0);
    chk({tag, "_wr"}, 32'(wr_o), 32'd0);
    chk({tag, "_drx"}, 32'(data_received_o), 32'd0);
    chk({tag, "_data"}, 32'(data_o), 32'd0);
    chk({tag, "_txv"}, 32'(tx_valid_o), 32'd0);
    chk({tag, "_txd"}, 32'(tx_data_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_drop"}, 32'(drop_o), 32'd0);
    chk({tag, "_tmo"}, 32'(timeout_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // write 0x3C to reg 5
    send_byte(8'h85);
    chk("wr_addr", 32'(address_o), 32'h05);
    chk("wr_flag", 32'(wr_o), 32'd1);
    chk("wr_busy", 32'(busy_o), 32'd1);
    send_byte(8'h3C);
    chk("wr_strobe", 32'(data_received_o), 32'd1);
    chk("wr_data", 32'(data_o), 32'h3C);
    @(negedge clk);
    chk("wr_strobe_end", 32'(data_received_o), 32'd0);
    chk("wr_flag_end", 32'(wr_o), 32'd0);
`ifdef CMD_ACK_EN
    chk("ack_valid", 32'(tx_valid_o), 32'd1);
    chk("ack_data", 32'(tx_data_o), 32'(ACK));
    drain();
`else
    chk("wr_idle", 32'(busy_o), 32'd0);
`endif

    // read reg 5 with the transmitter stalled, plus a dropped byte
    send_byte(8'h05);
    chk("rd_addr", 32'(address_o), 32'h05);
    chk("rd_txv_early", 32'(tx_valid_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rd_txv", 32'(tx_valid_o), 32'd1);
      chk("rd_txd", 32'(tx_data_o), 32'h3C);
    end
    send_byte(8'h11);
    chk("drop_pulse", 32'(drop_o), 32'd1);
    chk("drop_txd", 32'(tx_data_o), 32'h3C);
    chk("drop_addr", 32'(address_o), 32'h05);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("drop_end", 32'(drop_o), 32'd0);
    chk("rd_done_txv", 32'(tx_valid_o), 32'd0);
    chk("rd_done_busy", 32'(busy_o), 32'd0);
    tx_ready = 1'b0;

    // timeout of a write with no data byte
    send_byte(8'h90);
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge clk);
      chk("tmo_early", 32'(timeout_o), 32'd0);
    end
    @(negedge clk);
    chk("tmo_pulse", 32'(timeout_o), 32'd1);
    chk("tmo_busy", 32'(busy_o), 32'd0);
    chk("tmo_wr", 32'(wr_o), 32'd0);
    chk("tmo_drx", 32'(data_received_o), 32'd0);
    @(negedge clk);
    chk("tmo_end", 32'(timeout_o), 32'd0);

    // asynchronous reset while waiting for write data
    send_byte(8'hFF);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h01);
    chk("rst_rd_addr", 32'(address_o), 32'h01);
    chk("rst_rd_wr", 32'(wr_o), 32'd0);
    @(negedge clk);
    chk("rst_rd_txv", 32'(tx_valid_o), 32'd1);
    chk("rst_rd_txd", 32'(tx_data_o), 32'h5B);
    drain();

    // randomized traffic, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data = 8'($urandom);
      tx_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
